fir_interp_poly: RTL and testbench
==================================

Name: fir_interp_poly

Overview:
- Parametrised polyphase interpolating FIR. Successor to the fixed-rate transpose FIR.
- Accepts one signed input sample per valid/ready handshake and emits INTERP filtered output samples per input, i.e. upsample-by-INTERP plus filtering.
- Adds rounding, saturation and flow control in both directions.
- Sits between the sample source and downstream DAC/rate stages of the interpolation chain.

Parameters:
- DATA_WIDTH, 16, signed input/output sample width.
- TAP_COEFF_WIDTH, 16, signed coefficient width.
- NUM_TAPS, 32, total prototype filter taps; must be a multiple of INTERP.
- INTERP, 4, interpolation factor (>=2); TPP = NUM_TAPS/INTERP taps per phase.
- OUT_SHIFT, 15, right-shift applied to the accumulator before saturation (0 allowed).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  block accepts input this cycle.
- in  in  DATA_WIDTH  signed input sample.
- tap_coeffs  in  NUM_TAPS x TAP_COEFF_WIDTH  signed prototype coefficients h[0..NUM_TAPS-1], unpacked array; quasi-static, changed only while idle.
- out_valid  out  1  output sample present.
- out_ready  in  1  downstream accepts output.
- out  out  DATA_WIDTH  signed output sample.
- out_sat  out  1  the current out was saturated.

Behaviour:
- Delay line x[0..TPP-1], where x[0] is the newest sample. On an accepted input (in_valid & in_ready at an edge): x[k] <= x[k-1], x[0] <= in.
- Phase p result: y(p) = sum over k=0..TPP-1 of h[k*INTERP+p]*x[k].
  - Full-precision products; accumulator width DATA_WIDTH+TAP_COEFF_WIDTH+clog2(TPP)+1, no internal overflow.
- Output formatting:
  - Round half-up: add 2^(OUT_SHIFT-1) when OUT_SHIFT>0, then arithmetic shift right OUT_SHIFT.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; out_sat=1 iff clipped.
- FSM states: IDLE, LOAD, EMIT; phase counter 0..INTERP-1.
  - IDLE: in_ready=1, out_valid=0. On accept -> LOAD.
  - LOAD (1 cycle): in_ready=0. out <= y(0), out_sat set accordingly, phase<=0 -> EMIT.
  - EMIT: out_valid=1; out and out_sat held stable while out_ready=0.
  - EMIT, handshake with phase<INTERP-1: out <= y(phase+1), phase++.
  - EMIT, handshake with phase=INTERP-1: in_ready=1 combinationally in that cycle (in_ready = IDLE | (EMIT & phase==INTERP-1 & out_ready)).
    - If in_valid: accept -> LOAD.
    - Else -> IDLE, out_valid=0.
- Latency: input accepted at edge E0 -> out_valid=1 with phase-0 result after edge E1.
- Sustained throughput with in_valid=out_ready=1: INTERP outputs per INTERP+1 cycles; out_valid low exactly one cycle (LOAD) between bursts.
- Reset (async, any state including mid-burst):
  - State IDLE, phase 0, delay line all zero.
  - out=0, out_sat=0, out_valid=0; in_ready=1 from the first cycle after rst deasserts.
  - No partial burst resumes.
- tap_coeffs are read only in LOAD/EMIT. Changes outside IDLE give undefined output values but never a protocol violation.
- out_valid never drops without a handshake except on reset.

Test Plan:
- Impulse. Parameters: DATA_WIDTH=16, NUM_TAPS=8, INTERP=2, OUT_SHIFT=0; h[i]=i+1.
  - Stimulus: input 1, then 3 zeros, out_ready=1.
  - Expected: outputs 1,2,3,4,5,6,7,8, then zeros; out_sat=0.
- Backpressure. After the first output, hold out_ready=0 for 3 cycles.
  - Expected: out and out_valid stable, in_ready=0, no phase advance.
  - On release, the sequence continues unchanged with no sample lost or duplicated.
- Saturation. Parameters: DATA_WIDTH=8, TAP_COEFF_WIDTH=8, OUT_SHIFT=0, all h=127.
  - Input 127 -> every output 127 with out_sat=1.
  - Input -128 -> outputs -128, out_sat=1.
- Rounding. OUT_SHIFT=2, h[0]=1, others 0.
  - Input 6 -> phase-0 out 2, other phases 0.
  - Input -6 -> phase-0 out -1.
- Full flow. in_valid=out_ready=1 continuously, INTERP=4.
  - Expected: out_valid pattern 1111 0 repeating; one input accepted every 5 cycles; in_ready pulses coincide with the last-phase handshake.
- Reset mid-burst. Assert rst during phase 2 of a burst.
  - Expected: out_valid=0 and out=0 immediately.
  - Next impulse response matches a fresh start: zero delay line, no stale samples.

Source files
------------

// File: rtl/fir_interp_poly.sv
`default_nettype none
// ============================================================================
// Module   : fir_interp_poly
// Purpose  : Polyphase interpolating FIR. Each accepted input sample produces
//            INTERP output samples (one per polyphase branch). Each output is
//            rounded half-up, shifted right by OUT_SHIFT and saturated to
//            DATA_WIDTH. Valid/ready flow control is used on both sides.
// Ports    : clk, rst (async, active-high)
//            in_valid / in_ready / in          - input sample handshake
//            tap_coeffs[NUM_TAPS]              - prototype coefficients h[i]
//            out_valid / out_ready / out       - output sample handshake
//            out_sat                           - current out was clipped
// Revision : 1.0 - initial release
// ============================================================================
module fir_interp_poly #(
    parameter int DATA_WIDTH      = 16,
    parameter int TAP_COEFF_WIDTH = 16,
    parameter int NUM_TAPS        = 32,
    parameter int INTERP          = 4,
    parameter int OUT_SHIFT       = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in,
    input  logic [TAP_COEFF_WIDTH-1:0] tap_coeffs [NUM_TAPS],
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out,
    output logic                       out_sat
);

    localparam int TPP    = NUM_TAPS / INTERP;
    localparam int PH_W   = $clog2(INTERP);
    localparam int TIDX_W = $clog2(NUM_TAPS);
    localparam int PROD_W = DATA_WIDTH + TAP_COEFF_WIDTH;
    localparam int ACC_W  = DATA_WIDTH + TAP_COEFF_WIDTH + $clog2(TPP) + 1;

    // Half an output LSB; evaluates to zero when OUT_SHIFT is 0.
    localparam logic signed [ACC_W-1:0] c_round   = (ACC_W'(1) << OUT_SHIFT) >> 1;
    localparam logic signed [ACC_W-1:0] c_sat_max =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_sat_min =
        {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [DATA_WIDTH-1:0]   x_q [TPP];
    logic [DATA_WIDTH-1:0]   x_d [TPP];
    logic [DATA_WIDTH-1:0]   out_q, out_d;
    logic                    out_sat_q, out_sat_d;

    logic                    w_last_phase;
    logic [PH_W-1:0]         w_sel_phase;
    logic [TIDX_W-1:0]       w_tap_idx;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] w_rnd;
    logic signed [ACC_W-1:0] w_shift;
    logic [DATA_WIDTH-1:0]   w_fmt;
    logic                    w_fmt_sat;
    logic                    w_shift_en;

    assign w_last_phase = (phase_q == PH_W'(INTERP - 1));

    // Branch whose result is registered next: phase 0 in LOAD, phase+1 in EMIT.
    // Held at 0 on the last phase so the tap index never leaves the array.
    always_comb begin
        w_sel_phase = '0;
        if (state_q == EMIT && !w_last_phase) begin
            w_sel_phase = phase_q + 1'b1;
        end
    end

    // Polyphase MAC: branch p uses taps h[k*INTERP + p] against x[k].
    always_comb begin
        w_acc     = '0;
        w_prod    = '0;
        w_tap_idx = '0;
        for (int k = 0; k < TPP; k++) begin
            w_tap_idx = TIDX_W'(k * INTERP) + TIDX_W'(w_sel_phase);
            w_prod    = $signed(x_q[k]) * $signed(tap_coeffs[w_tap_idx]);
            w_acc     = w_acc + ACC_W'(w_prod);
        end
    end

    // Round half-up, arithmetic shift, then clip to the output range.
    always_comb begin
        w_rnd     = w_acc + c_round;
        w_shift   = w_rnd >>> OUT_SHIFT;
        w_fmt     = w_shift[DATA_WIDTH-1:0];
        w_fmt_sat = 1'b0;
        if (w_shift > c_sat_max) begin
            w_fmt     = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            w_fmt_sat = 1'b1;
        end else if (w_shift < c_sat_min) begin
            w_fmt     = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            w_fmt_sat = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        out_d      = out_q;
        out_sat_d  = out_sat_q;
        x_d        = x_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        w_shift_en = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_shift_en = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                out_d     = w_fmt;
                out_sat_d = w_fmt_sat;
                phase_d   = '0;
                state_d   = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (!w_last_phase) begin
                        out_d     = w_fmt;
                        out_sat_d = w_fmt_sat;
                        phase_d   = phase_q + 1'b1;
                    end else begin
                        // Final handshake of a burst doubles as an input slot
                        // so back-to-back bursts lose only the LOAD cycle.
                        in_ready = 1'b1;
                        if (in_valid) begin
                            w_shift_en = 1'b1;
                            state_d    = LOAD;
                        end else begin
                            state_d    = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_shift_en) begin
            x_d[0] = in;
            for (int k = 1; k < TPP; k++) begin
                x_d[k] = x_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            out_q     <= '0;
            out_sat_q <= 1'b0;
            for (int k = 0; k < TPP; k++) begin
                x_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            out_q     <= out_d;
            out_sat_q <= out_sat_d;
            x_q       <= x_d;
        end
    end

    assign out     = out_q;
    assign out_sat = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_interp_poly.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_interp_poly
// Purpose  : Self-checking bench for fir_interp_poly. A reference model forms
//            the zero-stuffed upsampled sequence and convolves it directly
//            with the prototype filter, then rounds and saturates.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_interp_poly;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int NT = 16;
    localparam int IP = 4;
    localparam int SH = 2;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data   = '0;
    logic [CW-1:0] coef [NT];
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_sat;

    int     total = 0;
    int     bad   = 0;
    longint expq[$];
    bit     expsat[$];
    longint hist[$];
    bit     just_loaded = 1'b0;
    bit     last_acc    = 1'b0;
    int     dut_acc     = 0;

    always #5 clk = ~clk;

    fir_interp_poly #(
        .DATA_WIDTH      (DW),
        .TAP_COEFF_WIDTH (CW),
        .NUM_TAPS        (NT),
        .INTERP          (IP),
        .OUT_SHIFT       (SH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in         (in_data),
        .tap_coeffs (coef),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out_data),
        .out_sat    (out_sat)
    );

    task automatic check_val(input string tag, input logic signed [63:0] obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output n*IP+p of the filter driven by the zero-stuffed input stream.
    function automatic void model_accept(input longint din);
        longint acc;
        longint r;
        int     n;
        int     m;
        int     q;
        longint vmax = (longint'(1) << (DW - 1)) - 1;
        longint vmin = -(longint'(1) << (DW - 1));
        hist.push_back(din);
        n = hist.size() - 1;
        for (int p = 0; p < IP; p++) begin
            m   = n * IP + p;
            acc = 0;
            for (int j = 0; j < NT; j++) begin
                q = m - j;
                if (q >= 0 && (q % IP) == 0)
                    acc += longint'($signed(coef[j])) * hist[q / IP];
            end
            r = (acc + ((longint'(1) << SH) / 2)) >>> SH;
            if (r > vmax) begin
                expq.push_back(vmax); expsat.push_back(1'b1);
            end else if (r < vmin) begin
                expq.push_back(vmin); expsat.push_back(1'b1);
            end else begin
                expq.push_back(r);    expsat.push_back(1'b0);
            end
        end
    endfunction

    // One clock: drive at negedge, check, then advance the model for the
    // handshakes that the coming rising edge will complete.
    task automatic cycle(input bit iv, input logic [DW-1:0] din, input bit ordy);
        bit exp_ir;
        bit exp_ov;
        @(negedge clk);
        in_valid  = iv;
        in_data   = din;
        out_ready = ordy;
        #1;
        exp_ir = (expq.size() == 0) || (expq.size() == 1 && ordy);
        exp_ov = (expq.size() > 0) && !just_loaded;
        check_val("in_ready", in_ready, exp_ir);
        check_val("out_valid", out_valid, exp_ov);
        if (in_valid && in_ready) dut_acc++;
        if (exp_ov) begin
            check_val("out", $signed(out_data), expq[0]);
            check_val("out_sat", out_sat, expsat[0]);
            if (ordy) begin
                void'(expq.pop_front());
                void'(expsat.pop_front());
            end
        end
        last_acc    = iv && exp_ir;
        just_loaded = last_acc;
        if (last_acc) model_accept(longint'($signed(din)));
        @(posedge clk);
    endtask

    task automatic push_sample(input logic [DW-1:0] din);
        int guard = 0;
        last_acc = 1'b0;
        while (!last_acc && guard < 40) begin
            cycle(1'b1, din, 1'b1);
            guard++;
        end
        if (!last_acc) check_val("push_timeout", 1, 0);
    endtask

    task automatic drain();
        int guard = 0;
        while ((expq.size() != 0 || just_loaded) && guard < 80) begin
            cycle(1'b0, '0, 1'b1);
            guard++;
        end
        if (guard >= 80) check_val("drain_timeout", 1, 0);
        cycle(1'b0, '0, 1'b1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out", $signed(out_data), 0);
        check_val("rst_out_sat", out_sat, 0);
        expq.delete();
        expsat.delete();
        hist.delete();
        just_loaded = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_impulse_coefs();
        for (int i = 0; i < NT; i++) coef[i] = CW'(i + 1);
    endtask

    initial begin
        int acc0;
        int guard;
        for (int i = 0; i < NT; i++) coef[i] = '0;
        apply_reset();

        // Impulse with backpressure after the first output.
        set_impulse_coefs();
        push_sample(16'sd4);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        repeat (3) cycle(1'b1, 16'sd7, 1'b0);
        repeat (3) push_sample('0);
        drain();

        // Saturation, both rails.
        for (int i = 0; i < NT; i++) coef[i] = 16'h7FFF;
        push_sample(16'sd32767);
        drain();
        apply_reset();
        push_sample(16'h8000);
        drain();

        // Rounding half-up on positive and negative values.
        apply_reset();
        for (int i = 0; i < NT; i++) coef[i] = '0;
        coef[0] = 16'd1;
        push_sample(16'sd6);
        push_sample(-16'sd6);
        drain();

        // Full flow: one accept every IP+1 cycles.
        set_impulse_coefs();
        acc0 = dut_acc;
        repeat (30) cycle(1'b1, DW'($urandom), 1'b1);
        check_val("flow_accepts", dut_acc - acc0, 6);
        drain();

        // Reset during phase 2, then a fresh impulse must show no history.
        push_sample(16'sd1000);
        guard = 0;
        while (expq.size() > 2 && guard < 20) begin
            cycle(1'b0, '0, 1'b1);
            guard++;
        end
        apply_reset();
        push_sample(16'sd4);
        repeat (3) push_sample('0);
        drain();

        // Randomized traffic with small and full-range coefficient sets.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NT; i++)
                coef[i] = (r == 0) ? CW'(int'($urandom_range(0, 511)) - 256) : CW'($urandom);
            repeat (300)
                cycle(($urandom % 4) != 0, DW'($urandom), ($urandom % 3) != 0);
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
